lif_tdm_scheduler: RTL and testbench

- Time-multiplexes one LIF update datapath across N_NEURONS neurons.
- Potentials and refractory counters are stored internally; one neuron is updated per clock inside each timestep.
- Sits between the spike-input fabric (one bit per neuron per timestep) and the downstream spike consumer.
- Replaces N parallel lif_neuron instances with one shared engine plus a state array.

---
 rtl/lif_pkg.sv | 49 ++++
 rtl/lif_update_core.sv | 27 ++
 rtl/lif_tdm_scheduler.sv | 136 +++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and the single-neuron LIF update function for the time-multiplexed
// scheduler.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [15:0] pot_t;
    typedef logic [3:0]  ref_t;

    localparam pot_t POT_MAX = 16'hFFFF;

    typedef struct packed {
        pot_t pot_next;
        ref_t ref_next;
        logic spike;
    } lif_res_t;

    function automatic lif_res_t lif_step(
        input pot_t       pot,
        input ref_t       ref_cnt,
        input logic       in_bit,
        input pot_t       weight,
        input pot_t       threshold,
        input logic [3:0] leak_shift,
        input ref_t       refrac
    );
        lif_res_t    res;
        logic [16:0] sum;
        pot_t        sat;
        res = '0;
        // The leak never exceeds pot, so the 17-bit sum cannot underflow.
        sum = {1'b0, pot} - {1'b0, pot >> leak_shift} + (in_bit ? {1'b0, weight} : 17'd0);
        sat = sum[16] ? POT_MAX : sum[15:0];
        if (ref_cnt != '0) begin
            res.ref_next = ref_cnt - 4'd1;
        end else if (sat >= threshold) begin
            res.spike    = 1'b1;
            res.ref_next = refrac;
        end else begin
            res.pot_next = sat;
        end
        return res;
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF update shared by all neurons of the scheduler.
module lif_update_core
    import lif_pkg::*;
#(
    parameter logic [15:0] WEIGHT       = 16'h0400,
    parameter logic [15:0] THRESHOLD    = 16'h1000,
    parameter int          LEAK_SHIFT   = 3,
    parameter int          REFRAC_STEPS = 2
) (
    input  logic [15:0] pot,
    input  logic [3:0]  ref_cnt,
    input  logic        in_bit,
    output logic [15:0] pot_next,
    output logic [3:0]  ref_next,
    output logic        spike
);
    lif_res_t res;

    always_comb begin
        res      = lif_step(pot, ref_cnt, in_bit, WEIGHT, THRESHOLD,
                            4'(LEAK_SHIFT), 4'(REFRAC_STEPS));
        pot_next = res.pot_next;
        ref_next = res.ref_next;
        spike    = res.spike;
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// One shared LIF engine stepping through N_NEURONS stored neuron states, one per clock.
// state | meaning
// IDLE  | waiting for step_start; applies clr_pots immediately
// RUN   | updating neuron idx each edge
// DONE  | one-cycle step_done; applies any pending clear on exit
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int          N_NEURONS    = 8,
    parameter logic [15:0] WEIGHT       = 16'h0400,
    parameter logic [15:0] THRESHOLD    = 16'h1000,
    parameter int          LEAK_SHIFT   = 3,
    parameter int          REFRAC_STEPS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_start,
    input  logic [N_NEURONS-1:0]           in_bits,
    input  logic                           clr_pots,
    output logic                           busy,
    output logic                           step_done,
    output logic [N_NEURONS-1:0]           spike_vec,
    output logic [$clog2(N_NEURONS+1)-1:0] spike_count,
    output logic                           overrun,
    input  logic [$clog2(N_NEURONS)-1:0]   rd_idx,
    output logic [15:0]                    rd_pot
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int CNT_W = $clog2(N_NEURONS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t               state;
    pot_t                 pots [N_NEURONS];
    ref_t                 refs [N_NEURONS];
    logic [N_NEURONS-1:0] shadow;
    logic [N_NEURONS-1:0] work;
    logic [N_NEURONS-1:0] work_next;
    logic [CNT_W-1:0]     count_next;
    logic [IDX_W-1:0]     idx;
    logic                 clr_pend;
    pot_t                 core_pot;
    ref_t                 core_ref;
    logic                 core_spike;

    lif_update_core #(
        .WEIGHT       (WEIGHT),
        .THRESHOLD    (THRESHOLD),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS)
    ) u_core (
        .pot      (pots[idx]),
        .ref_cnt  (refs[idx]),
        .in_bit   (shadow[idx]),
        .pot_next (core_pot),
        .ref_next (core_ref),
        .spike    (core_spike)
    );

    // spike_vec must include the last neuron's result on the same edge that enters DONE.
    always_comb begin
        work_next      = work;
        work_next[idx] = core_spike;
        count_next     = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            count_next = count_next + CNT_W'(work_next[i]);
        end
    end

    assign busy      = (state != ST_IDLE);
    assign step_done = (state == ST_DONE);
    assign rd_pot    = pots[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            work        <= '0;
            idx         <= '0;
            clr_pend    <= 1'b0;
            spike_vec   <= '0;
            spike_count <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                pots[i] <= '0;
                refs[i] <= '0;
            end
        end else begin
            if (step_start && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (clr_pots || clr_pend) begin
                        clr_pend <= 1'b0;
                        for (int i = 0; i < N_NEURONS; i++) begin
                            pots[i] <= '0;
                            refs[i] <= '0;
                        end
                    end else if (step_start) begin
                        shadow <= in_bits;
                        work   <= '0;
                        idx    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    pots[idx] <= core_pot;
                    refs[idx] <= core_ref;
                    work      <= work_next;
                    if (clr_pots) begin
                        clr_pend <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        spike_vec   <= work_next;
                        spike_count <= count_next;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    clr_pend <= 1'b0;
                    if (clr_pots || clr_pend) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            pots[i] <= '0;
                            refs[i] <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler: a default-parameter instance plus a
// saturation-configured instance, all expectations hand-computed.
module tb_lif_tdm_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        step_start = 1'b0;
    logic [3:0]  in_bits    = 4'b0;
    logic        clr_pots   = 1'b0;
    logic [1:0]  rd_idx     = 2'd0;
    logic        busy, step_done, overrun;
    logic [3:0]  spike_vec;
    logic [2:0]  spike_count;
    logic [15:0] rd_pot;

    logic        s_step_start = 1'b0;
    logic [3:0]  s_in_bits    = 4'b0;
    logic        s_clr_pots   = 1'b0;
    logic [1:0]  s_rd_idx     = 2'd0;
    logic        s_busy, s_step_done, s_overrun;
    logic [3:0]  s_spike_vec;
    logic [2:0]  s_spike_count;
    logic [15:0] s_rd_pot;

    int checks = 0;
    int errors = 0;

    logic [15:0] acc_pot [9] = '{16'h0400, 16'h0780, 16'h0A90, 16'h0D3E, 16'h0F97,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0400};
    logic [3:0]  acc_spk [9] = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0};
    logic [15:0] bld_pot [4] = '{16'h060E, 16'h094D, 16'h0C24, 16'h0EA0};

    always #5 clk = ~clk;

    lif_tdm_scheduler #(.N_NEURONS(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .step_start  (step_start),
        .in_bits     (in_bits),
        .clr_pots    (clr_pots),
        .busy        (busy),
        .step_done   (step_done),
        .spike_vec   (spike_vec),
        .spike_count (spike_count),
        .overrun     (overrun),
        .rd_idx      (rd_idx),
        .rd_pot      (rd_pot)
    );

    lif_tdm_scheduler #(.N_NEURONS(4), .WEIGHT(16'hC000), .THRESHOLD(16'hFFFF)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .step_start  (s_step_start),
        .in_bits     (s_in_bits),
        .clr_pots    (s_clr_pots),
        .busy        (s_busy),
        .step_done   (s_step_done),
        .spike_vec   (s_spike_vec),
        .spike_count (s_spike_count),
        .overrun     (s_overrun),
        .rd_idx      (s_rd_idx),
        .rd_pot      (s_rd_pot)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_pot(input string tag, input logic [1:0] idx, input logic [15:0] exp);
        rd_idx = idx;
        #1;
        chk(tag, 32'(rd_pot), 32'(exp));
    endtask

    // Launches one step and waits (bounded) for its step_done, ending back in IDLE.
    task automatic run_step(input logic sat, input logic [3:0] bits, input logic clr_mid);
        logic seen;
        if (sat) begin
            s_step_start = 1'b1;
            s_in_bits    = bits;
        end else begin
            step_start = 1'b1;
            in_bits    = bits;
        end
        @(negedge clk);
        step_start   = 1'b0;
        s_step_start = 1'b0;
        in_bits      = ~bits;
        s_in_bits    = ~bits;
        if (clr_mid) begin
            clr_pots = 1'b1;
            @(negedge clk);
            clr_pots = 1'b0;
        end
        seen = sat ? s_step_done : step_done;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = sat ? s_step_done : step_done;
        end
        chk("step_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(step_done), 32'd0);
        chk("rst_spike_vec", 32'(spike_vec), 32'd0);
        chk("rst_spike_count", 32'(spike_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk_pot("rst_pot0", 2'd0, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_step(1'b0, 4'b0001, 1'b0);
            chk_pot("acc_pot0", 2'd0, acc_pot[i]);
            chk("acc_spike_vec", 32'(spike_vec), 32'(acc_spk[i]));
            if (i == 5) chk("acc_spike_count", 32'(spike_count), 32'd1);
        end

        run_step(1'b0, 4'b0010, 1'b0);
        chk_pot("leak_pot1_a", 2'd1, 16'h0400);
        run_step(1'b0, 4'b0000, 1'b0);
        chk_pot("leak_pot1_b", 2'd1, 16'h0380);
        run_step(1'b0, 4'b0000, 1'b0);
        chk_pot("leak_pot1_c", 2'd1, 16'h0310);
        chk_pot("leak_pot0", 2'd0, 16'h02AE);
        chk("leak_spike_vec", 32'(spike_vec), 32'd0);
        chk("ovr_before", 32'(overrun), 32'd0);

        step_start = 1'b1;
        in_bits    = 4'b0000;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            step_start = (c == 1);
            chk("tim_busy", 32'(busy), 32'(c <= 4));
            chk("tim_done", 32'(step_done), 32'(c == 4));
        end
        step_start = 1'b0;
        chk("tim_overrun", 32'(overrun), 32'd1);
        chk_pot("tim_pot0", 2'd0, 16'h0259);

        for (int i = 0; i < 4; i++) begin
            run_step(1'b0, 4'b0001, 1'b0);
            chk_pot("bld_pot0", 2'd0, bld_pot[i]);
        end
        run_step(1'b0, 4'b0001, 1'b1);
        chk("clr_spike_vec", 32'(spike_vec), 32'd1);
        chk("clr_spike_count", 32'(spike_count), 32'd1);
        for (int n = 0; n < 4; n++) chk_pot("clr_pot", 2'(n), 16'h0000);

        step_start = 1'b1;
        in_bits    = 4'b0001;
        @(negedge clk);
        step_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(step_done), 32'd0);
        chk("rstmid_spike_vec", 32'(spike_vec), 32'd0);
        chk("rstmid_spike_count", 32'(spike_count), 32'd0);
        chk("rstmid_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_step(1'b0, 4'b0001, 1'b0);
        chk_pot("post_rst_pot0", 2'd0, 16'h0400);

        clr_pots   = 1'b1;
        step_start = 1'b1;
        in_bits    = 4'b0001;
        @(negedge clk);
        clr_pots   = 1'b0;
        step_start = 1'b0;
        chk("clrst_busy", 32'(busy), 32'd0);
        chk("clrst_overrun", 32'(overrun), 32'd0);
        chk_pot("clrst_pot0", 2'd0, 16'h0000);

        run_step(1'b1, 4'b0001, 1'b0);
        s_rd_idx = 2'd0;
        #1;
        chk("sat_pot_a", 32'(s_rd_pot), 32'h0000C000);
        chk("sat_spike_a", 32'(s_spike_vec), 32'd0);
        run_step(1'b1, 4'b0001, 1'b0);
        #1;
        chk("sat_pot_b", 32'(s_rd_pot), 32'd0);
        chk("sat_spike_b", 32'(s_spike_vec), 32'd1);
        chk("sat_count_b", 32'(s_spike_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
